// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake and a one-entry skid
// buffer. It carries an opaque payload and a control field, and supports flush,
// a global enable, a sticky halt flag and a saturating back-pressure counter.
module pipe_stage_skid #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              en,
    input  logic              flush,
    input  logic              stall_clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              in_halt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic              out_halt,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Occupancy encoding: bit 0 is the main valid bit, bit 1 the skid valid bit.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        HALF  = 2'b01,
        FULL  = 2'b11
    } state_t;

    state_t state, state_nx;

    logic [DATA_W-1:0] main_data, skid_data;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic              main_halt, skid_halt;
    logic              main_valid, skid_valid;
    logic              halt_pending;
    logic              accept, pop;
    logic              load_main_in, load_main_skid, load_skid_in;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) return v;
        return v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign main_valid = state[0];
    assign skid_valid = state[1];

    // Ready comes from registers only, so it never depends on this cycle's inputs.
    assign in_ready  = ~skid_valid & ~halt_pending;
    assign accept    = in_valid & in_ready & en & ~flush;
    assign pop       = main_valid & out_ready & en;

    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign out_ctrl  = main_ctrl & {CTRL_W{main_valid}};

    // Occupancy state register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= EMPTY;
        else       state <= state_nx;
    end

    // Next occupancy and register load selects; flush overrides everything.
    always_comb begin
        state_nx       = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid_in   = 1'b0;
        if (en) begin
            if (flush) begin
                state_nx = EMPTY;
            end else begin
                case (state)
                    EMPTY: begin
                        if (accept) begin
                            state_nx     = HALF;
                            load_main_in = 1'b1;
                        end
                    end
                    HALF: begin
                        if (accept && pop) begin
                            load_main_in = 1'b1;
                        end else if (accept) begin
                            state_nx     = FULL;
                            load_skid_in = 1'b1;
                        end else if (pop) begin
                            state_nx = EMPTY;
                        end
                    end
                    FULL: begin
                        if (pop) begin
                            state_nx       = HALF;
                            load_main_skid = 1'b1;
                        end
                    end
                    default: state_nx = EMPTY;
                endcase
            end
        end
    end

    // Main and skid payload registers; the skid entry always moves to main first.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            main_data <= '0;
            main_ctrl <= '0;
            main_halt <= 1'b0;
            skid_data <= '0;
            skid_ctrl <= '0;
            skid_halt <= 1'b0;
        end else begin
            if (load_main_in) begin
                main_data <= in_data;
                main_ctrl <= in_ctrl;
                main_halt <= in_halt;
            end else if (load_main_skid) begin
                main_data <= skid_data;
                main_ctrl <= skid_ctrl;
                main_halt <= skid_halt;
            end
            if (load_skid_in) begin
                skid_data <= in_data;
                skid_ctrl <= in_ctrl;
                skid_halt <= in_halt;
            end
        end
    end

    // Halt bookkeeping: block further input once a halt is taken; out_halt is sticky.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            halt_pending <= 1'b0;
            out_halt     <= 1'b0;
        end else begin
            if (en) begin
                if (flush)                  halt_pending <= 1'b0;
                else if (accept && in_halt) halt_pending <= 1'b1;
            end
            // A pop in a flush cycle still completes, so it can raise out_halt.
            if (pop && main_halt) out_halt <= 1'b1;
        end
    end

    // Saturating count of cycles where an entry waits on downstream.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt <= '0;
        end else if (en) begin
            if (stall_clr)                      stall_cnt <= '0;
            else if (main_valid && !out_ready)  stall_cnt <= sat_inc(stall_cnt);
        end
    end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised inter-stage pipeline register with valid/ready handshake and a one-entry skid buffer, the successor to the fixed EX/MEM latch. It sits between any two datapath stages (IF/ID, ID/EX, EX/MEM, MEM/WB) and carries an opaque payload plus a control field. It supports flush, a global enable, a sticky committed-halt flag and a saturating back-pressure counter. Control outputs are forced to zero whenever no valid entry is presented, so downstream logic sees a NOP bubble.

## Interface
- DATA_W, 96: payload width (PCs, operands, ALU result, wsel, ...).
- CTRL_W, 8: control-field width (RegWr, MemWr, MemRd, MemtoReg, PCSrc, ...).
- CNT_W, 16: stall counter width.

- CLK  input  1  clock, rising edge.
- nRST  input  1  reset, asynchronous, active-low.
- en  input  1  global enable; 0 freezes all state.
- flush  input  1  discard all held entries at the next edge.
- stall_clr  input  1  synchronous clear of stall_cnt.
- in_valid  input  1  upstream has an entry.
- in_ready  output  1  block can accept.
- in_data  input  DATA_W  payload.
- in_ctrl  input  CTRL_W  control field.
- in_halt  input  1  entry is a halt instruction.
- out_valid  output  1  main register holds an entry.
- out_ready  input  1  downstream accepts.
- out_data  output  DATA_W  main payload.
- out_ctrl  output  CTRL_W  main control, 0 when out_valid=0.
- out_halt  output  1  sticky: a halt entry has been popped.
- stall_cnt  output  CNT_W  saturating back-pressure cycle count.

## Operation
- Storage: main register (drives outputs) and skid register, each with a valid bit and a halt bit.
- State is derived from the valid bits:
  - EMPTY: main and skid both invalid.
  - HALF: main valid, skid invalid.
  - FULL: main and skid both valid.
- accept = in_valid & in_ready & en & ~flush.
- pop = out_valid & out_ready & en.
- in_ready = ~skid_valid & ~halt_pending, driven from registers only.
- Transitions:
  - EMPTY + accept → HALF; main ← in.
  - HALF + accept & pop → HALF; main ← in.
  - HALF + accept & ~pop → FULL; skid ← in.
  - HALF + ~accept & pop → EMPTY.
  - FULL + pop → HALF; main ← skid, skid invalidated.
  - Otherwise hold.
- Ordering is strict FIFO: a skid entry always leaves before any newer entry.
- flush:
  - Next state is EMPTY from any state, with both valid bits cleared.
  - accept is suppressed in the flush cycle.
  - A pop in the flush cycle is a completed transfer; downstream owns that entry.
- halt_pending:
  - Set on accept with in_halt=1.
  - Cleared by flush.
  - While set, in_ready=0, so no entry after a halt is taken.
- out_halt: set at the edge following a pop whose main halt bit is 1. Cleared only by nRST; flush does not clear it.
- en=0: no accept, no pop, no flush effect, no state change, stall_cnt holds. in_ready and out_* keep their register-derived values.
- out_data holds its last loaded value when invalid and is not zeroed. out_ctrl = main_ctrl & {CTRL_W{out_valid}}.
- stall_cnt:
  - Increments on each cycle with en & out_valid & ~out_ready.
  - Saturates at 2^CNT_W−1.
  - stall_clr forces it to 0 at the edge; clear wins over increment.
  - Unaffected by flush.

## Timing
- Reset (nRST low, asynchronous):
  - All valid bits, halt_pending, out_halt and stall_cnt are 0.
  - out_data and out_ctrl are 0.
  - in_ready=1 and out_valid=0 immediately.
- Latency: an entry accepted at edge N into an EMPTY block gives out_valid=1 after edge N.
- Throughput: 1 entry/cycle sustained while out_ready=1.
- Back-pressure: in_ready falls one edge after the first unpopped accept with the block in HALF (skid filled). Upstream may present at most one extra entry, and no data is lost.
- in_ready rises the edge after a pop from FULL.
- Reset asserted mid-transfer discards all entries. The first accept is legal on the first edge after nRST deasserts.
- flush with accept and pop in the same cycle: the pop completes, the offered input is dropped, and the block is EMPTY after the edge.

## Test plan
- Streaming: out_ready=1, feed data 1..10 back-to-back → out_data 1..10 in order, each one cycle after its accept, stall_cnt=0.
- Skid: hold out_ready=0 while feeding A, B, C.
  - A and B are accepted; in_ready=0 after B; C is held upstream.
  - Raise out_ready → A, B, C emerge in order, with no gaps once flowing.
- Flush from FULL: flush=1 with in_valid=1 → EMPTY next cycle, out_valid=0, out_ctrl=0, input not accepted, in_ready=1.
- Halt:
  - Feed X, then H(halt=1), then Y → Y is refused (in_ready=0 after H).
  - out_halt=1 the cycle after H pops and remains 1 through a later flush.
  - Separately, flush H before its pop → out_halt stays 0 and in_ready returns to 1.
- Enable freeze and counters:
  - en=0 for 5 cycles in HALF with out_ready=0 → no change, stall_cnt unchanged.
  - CNT_W=4 with 20 stalled cycles → stall_cnt=15.
  - stall_clr → 0.
- Async reset: drop nRST in FULL mid-cycle → out_valid=0 and in_ready=1 immediately, without waiting for a clock edge.
